d_register_pipe: RTL

//  Parametrised, valid-tagged pipeline of D registers with a global stall

---
 rtl/d_register_pipe.sv | 89 ++++++++
 1 files changed

// File: rtl/d_register_pipe.sv
// d_register_pipe: valid-tagged pipeline of WIDTH-bit D registers, DEPTH
// stages deep, with a global advance enable and a registered occupancy count
// of the stages currently holding valid data.
//
// Optional feature: define D_REG_PIPE_FLUSH_EN to add a `flush` input that
// clears every valid tag (and the occupancy count) on the next rising edge,
// with priority over `en`. Data registers are never touched by a flush.
module d_register_pipe #(
  parameter int unsigned             WIDTH       = 8,
  parameter int unsigned             DEPTH       = 4,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          en,
`ifdef D_REG_PIPE_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          d_valid,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic [WIDTH-1:0]              q_bar,
  output logic                          q_valid,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             flush_w;

`ifdef D_REG_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  // Without the feature the pipe behaves exactly as if flush were tied low.
  assign flush_w = 1'b0;
`endif

  // Data stages: shift on every enabled edge, regardless of the valid tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data array is reset on purpose: the last stage drives q
      // directly, and q must show RESET_VALUE as soon as reset asserts.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VALUE;
    end else if (en && !flush_w) begin
      // NOTE: non-blocking assignments let every stage take its neighbour's
      // old value in the same edge; blocking ones would collapse the shift.
      data_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  // Next state of valid tags and occupancy; flush wins over en.
  always_comb begin
    // NOTE: defaults first, so every path assigns both signals (no latches).
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush_w) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) valid_d[i] = valid_q[i-1];
      // Entry and exit in the same edge cancel; the count tracks the tag
      // popcount, so it can neither exceed DEPTH nor underflow.
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  // Valid-tag and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Outputs come straight from last-stage registers: no path from d to q.
  assign q         = data_q[DEPTH-1];
  assign q_bar     = ~data_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
